// File: rtl/character_motion.sv
// Per-player sprite controller: frame-rate walk/jump/gravity motion plus the
// per-pixel coverage test and sprite ROM addressing (pose bank, mirroring).
module character_motion #(
    parameter int SPR_W   = 32,
    parameter int SPR_H   = 32,
    parameter int START_X = 40,
    parameter int START_Y = 400,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 607,
    parameter int Y_MIN   = 0,
    parameter int FLOOR_Y = 440,
    parameter int H_SPEED = 2,
    parameter int JUMP_V  = 12,
    parameter int GRAVITY = 1,
    parameter int V_MAX   = 10,
    parameter int AW      = $clog2(4*SPR_W*SPR_H)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_clk,
    input  logic          left_key,
    input  logic          right_key,
    input  logic          jump_key,
    input  logic          solid_below,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    output logic [9:0]    pos_x,
    output logic [9:0]    pos_y,
    output logic          facing_left,
    output logic [1:0]    pose,
    output logic          is_sprite,
    output logic [AW-1:0] sprite_address
);
    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam logic signed [10:0] XMIN_S  = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S  = 11'(X_MAX);
    localparam logic signed [10:0] YMIN_S  = 11'(Y_MIN);
    localparam logic signed [10:0] FLOOR_S = 11'(FLOOR_Y);
    localparam logic signed [10:0] HSPD_S  = 11'(H_SPEED);
    localparam logic [4:0] GRAV5 = 5'(GRAVITY);

    typedef enum logic [1:0] {GROUND, RISE, FALL} vstate_t;

    vstate_t            state;
    logic [4:0]         vy, vy_fall;
    logic [5:0]         vy_inc;
    logic               frame_q, frame_edge;
    logic               go_left, go_right, one_dir;
    logic signed [10:0] x_l, x_r, y_up, y_dn;

    assign frame_edge = frame_clk & ~frame_q;
    assign go_left    = left_key & ~right_key;
    assign go_right   = right_key & ~left_key;
    assign one_dir    = go_left | go_right;

    // 11-bit signed so edges of the screen clamp instead of wrapping
    assign x_l     = $signed({1'b0, pos_x}) - HSPD_S;
    assign x_r     = $signed({1'b0, pos_x}) + HSPD_S;
    assign y_up    = $signed({1'b0, pos_y}) - $signed({6'b0, vy});
    assign vy_inc  = {1'b0, vy} + 6'(GRAVITY);
    assign vy_fall = (vy_inc > 6'(V_MAX)) ? 5'(V_MAX) : vy_inc[4:0];
    assign y_dn    = $signed({1'b0, pos_y}) + $signed({6'b0, vy_fall});

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q     <= 1'b0;
            pos_x       <= 10'(START_X);
            pos_y       <= 10'(START_Y);
            vy          <= '0;
            state       <= GROUND;
            facing_left <= 1'b0;
            pose        <= 2'd0;
        end else begin
            frame_q <= frame_clk;
            if (frame_edge) begin
                if (go_left) begin
                    pos_x       <= (x_l < XMIN_S) ? 10'(X_MIN) : x_l[9:0];
                    facing_left <= 1'b1;
                end else if (go_right) begin
                    pos_x       <= (x_r > XMAX_S) ? 10'(X_MAX) : x_r[9:0];
                    facing_left <= 1'b0;
                end
                // pose always reflects the state being entered this frame
                case (state)
                    GROUND: begin
                        if (jump_key) begin
                            vy    <= 5'(JUMP_V);
                            state <= RISE;
                            pose  <= 2'd2;
                        end else if (!solid_below && pos_y != 10'(FLOOR_Y)) begin
                            vy    <= '0;
                            state <= FALL;
                            pose  <= 2'd3;
                        end else begin
                            pose  <= {1'b0, one_dir};
                        end
                    end
                    RISE: begin
                        if (y_up <= YMIN_S) begin
                            pos_y <= 10'(Y_MIN);
                            vy    <= '0;
                            state <= FALL;
                            pose  <= 2'd3;
                        end else begin
                            pos_y <= y_up[9:0];
                            if (vy <= GRAV5) begin
                                vy    <= '0;
                                state <= FALL;
                                pose  <= 2'd3;
                            end else begin
                                vy    <= vy - GRAV5;
                                pose  <= 2'd2;
                            end
                        end
                    end
                    FALL: begin
                        if (y_dn >= FLOOR_S) begin
                            pos_y <= 10'(FLOOR_Y);
                            vy    <= '0;
                            state <= GROUND;
                            pose  <= {1'b0, one_dir};
                        end else if (solid_below) begin
                            vy    <= '0;
                            state <= GROUND;
                            pose  <= {1'b0, one_dir};
                        end else begin
                            pos_y <= y_dn[9:0];
                            vy    <= vy_fall;
                            pose  <= 2'd3;
                        end
                    end
                    default: state <= GROUND;
                endcase
            end
        end
    end

    logic [10:0]   x_end, y_end;
    logic [CW-1:0] col_raw, col;
    logic [RW-1:0] row;

    assign x_end     = {1'b0, pos_x} + 11'(SPR_W);
    assign y_end     = {1'b0, pos_y} + 11'(SPR_H);
    assign is_sprite = (DrawX >= pos_x) && ({1'b0, DrawX} < x_end) &&
                       (DrawY >= pos_y) && ({1'b0, DrawY} < y_end);
    assign col_raw   = CW'(DrawX - pos_x);
    assign col       = facing_left ? (CW'(SPR_W-1) - col_raw) : col_raw;
    assign row       = RW'(DrawY - pos_y);
    assign sprite_address = is_sprite ?
        (AW'(pose) * AW'(SPR_W*SPR_H) + AW'(row) * AW'(SPR_W) + AW'(col)) : '0;
endmodule

// File: tb/tb_character_motion.sv
// Bench for character_motion: directed motion/pixel scenarios and random key
// streams compared frame by frame against an integer reference model.
module tb_character_motion;
    localparam int SPR_W = 32, SPR_H = 32, START_X = 40, START_Y = 400;
    localparam int X_MIN = 0, X_MAX = 607, Y_MIN = 0, FLOOR_Y = 440;
    localparam int H_SPEED = 2, JUMP_V = 12, GRAVITY = 1, V_MAX = 10;
    localparam int AW = 12;
    localparam int ON_GROUND = 0, RISING = 1, FALLING = 2;

    logic          Clk = 0, Reset = 0, frame_clk = 0;
    logic          left_key = 0, right_key = 0, jump_key = 0, solid_below = 0;
    logic [9:0]    DrawX = 0, DrawY = 0;
    logic [9:0]    pos_x, pos_y;
    logic          facing_left, is_sprite;
    logic [1:0]    pose;
    logic [AW-1:0] sprite_address;

    int checks = 0, errors = 0;
    int mx, my, mvy, mmode, mfacing, mpose;

    character_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .left_key(left_key), .right_key(right_key), .jump_key(jump_key),
        .solid_below(solid_below), .DrawX(DrawX), .DrawY(DrawY),
        .pos_x(pos_x), .pos_y(pos_y), .facing_left(facing_left), .pose(pose),
        .is_sprite(is_sprite), .sprite_address(sprite_address)
    );

    always #10 Clk = ~Clk;

    task automatic model_reset();
        mx = START_X; my = START_Y; mvy = 0; mmode = ON_GROUND; mfacing = 0; mpose = 0;
    endtask

    task automatic model_edge(input bit l, input bit r, input bit j, input bit s);
        if (l && !r) begin
            mx = (mx - H_SPEED < X_MIN) ? X_MIN : mx - H_SPEED; mfacing = 1;
        end else if (r && !l) begin
            mx = (mx + H_SPEED > X_MAX) ? X_MAX : mx + H_SPEED; mfacing = 0;
        end
        if (mmode == ON_GROUND) begin
            if (j) begin mvy = JUMP_V; mmode = RISING; end
            else if (!s && my != FLOOR_Y) begin mvy = 0; mmode = FALLING; end
        end else if (mmode == RISING) begin
            if (my - mvy <= Y_MIN) begin my = Y_MIN; mvy = 0; mmode = FALLING; end
            else begin
                my = my - mvy;
                if (mvy <= GRAVITY) begin mvy = 0; mmode = FALLING; end
                else mvy = mvy - GRAVITY;
            end
        end else begin
            mvy = (mvy + GRAVITY > V_MAX) ? V_MAX : mvy + GRAVITY;
            if (my + mvy >= FLOOR_Y) begin my = FLOOR_Y; mvy = 0; mmode = ON_GROUND; end
            else if (s) begin mvy = 0; mmode = ON_GROUND; end
            else my = my + mvy;
        end
        mpose = (mmode == RISING) ? 2 : (mmode == FALLING) ? 3 : ((l ^ r) ? 1 : 0);
    endtask

    function automatic int exp_addr(input int dx, input int dy);
        int col;
        if (dx < mx || dx >= mx + SPR_W || dy < my || dy >= my + SPR_H) return 0;
        col = mfacing ? SPR_W - 1 - (dx - mx) : dx - mx;
        return mpose * SPR_W * SPR_H + (dy - my) * SPR_W + col;
    endfunction

    task automatic frame(input bit l, input bit r, input bit j, input bit s);
        @(negedge Clk);
        left_key = l; right_key = r; jump_key = j; solid_below = s; frame_clk = 1;
        model_edge(l, r, j, s);
        repeat (2) @(negedge Clk);
        frame_clk = 0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset = 1; left_key = 0; right_key = 0; jump_key = 0; solid_below = 0;
        @(negedge Clk);
        Reset = 0;
        model_reset();
        checks++;
        if ({pos_x, pos_y, facing_left, pose} !== {10'd40, 10'd400, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset: x=%0d y=%0d f=%0d p=%0d want 40 400 0 0", pos_x, pos_y, facing_left, pose);
        end
        DrawX = 40; DrawY = 400; #1;
        checks++;
        if ({is_sprite, sprite_address} !== {1'b1, 12'd0}) begin
            errors++;
            $display("FAIL reset_pixel: is=%0d addr=%0d want 1 0", is_sprite, sprite_address);
        end
    endtask

    task automatic test_walk_left();
        for (int k = 1; k <= 30; k++) begin
            frame(1, 0, 0, 1);
            checks++;
            if (pos_x !== 10'((40 - 2*k < 0) ? 0 : 40 - 2*k) ||
                {pos_y, facing_left, pose} !== {10'(my), 1'b1, 2'd1}) begin
                errors++;
                $display("FAIL walk_left k=%0d: x=%0d y=%0d f=%0d p=%0d want x=%0d y=%0d 1 1",
                         k, pos_x, pos_y, facing_left, pose, (40-2*k < 0) ? 0 : 40-2*k, my);
            end
        end
        // walk off the ledge and fall to the floor
        for (int k = 0; k < 40; k++) begin
            frame(0, 0, 0, 0);
            checks++;
            if ({pos_x, pos_y, facing_left, pose} !== {10'(mx), 10'(my), 1'(mfacing), 2'(mpose)}) begin
                errors++;
                $display("FAIL drop k=%0d: x=%0d y=%0d f=%0d p=%0d want %0d %0d %0d %0d",
                         k, pos_x, pos_y, facing_left, pose, mx, my, mfacing, mpose);
            end
            if (mmode == ON_GROUND && my == FLOOR_Y) break;
        end
        checks++;
        if (pos_y !== 10'd440) begin
            errors++; $display("FAIL drop_floor: y=%0d want 440", pos_y);
        end
    endtask

    task automatic test_jump();
        int exp_y[4] = '{440, 428, 417, 407};
        for (int k = 0; k < 4; k++) begin
            frame(0, 0, 1, 0);
            checks++;
            if (pos_y !== 10'(exp_y[k]) || pose !== 2'd2) begin
                errors++;
                $display("FAIL jump_rise k=%0d: y=%0d p=%0d want %0d 2", k, pos_y, pose, exp_y[k]);
            end
        end
        // jump held all the way through the air: must not re-launch
        for (int k = 0; k < 60 && mmode != ON_GROUND; k++) begin
            frame(0, 0, 1, 0);
            checks++;
            if ({pos_y, pose} !== {10'(my), 2'(mpose)}) begin
                errors++;
                $display("FAIL jump_air k=%0d: y=%0d p=%0d want %0d %0d", k, pos_y, pose, my, mpose);
            end
        end
        checks++;
        if ({pos_y, pose} !== {10'd440, 2'd0}) begin
            errors++; $display("FAIL jump_land: y=%0d p=%0d want 440 0", pos_y, pose);
        end
        frame(0, 0, 0, 0);
    endtask

    task automatic test_solid();
        int y_land;
        frame(0, 0, 1, 0);
        for (int k = 0; k < 30 && mmode != FALLING; k++) frame(0, 0, 0, 0);
        frame(0, 0, 0, 0);
        y_land = my;
        frame(0, 0, 0, 1);
        checks++;
        if ({pos_y, pose} !== {10'(y_land), 2'd0}) begin
            errors++; $display("FAIL solid_land: y=%0d p=%0d want %0d 0", pos_y, pose, y_land);
        end
        frame(0, 0, 0, 0);
        checks++;
        if ({pos_y, pose} !== {10'(y_land), 2'd3}) begin
            errors++; $display("FAIL solid_walkoff: y=%0d p=%0d want %0d 3", pos_y, pose, y_land);
        end
        frame(0, 0, 0, 0);
        checks++;
        if (pos_y !== 10'(y_land + 1)) begin
            errors++; $display("FAIL solid_refall: y=%0d want %0d", pos_y, y_land + 1);
        end
        for (int k = 0; k < 40 && mmode != ON_GROUND; k++) frame(0, 0, 0, 0);
    endtask

    task automatic test_pixel();
        while (mx < 100) frame(0, 1, 0, 1);
        frame(0, 0, 0, 1);
        DrawX = 100; DrawY = 10'(my); #1;
        checks++;
        if ({pos_x, is_sprite, sprite_address} !== {10'd100, 1'b1, 12'd0}) begin
            errors++;
            $display("FAIL pix_origin: x=%0d is=%0d addr=%0d want 100 1 0", pos_x, is_sprite, sprite_address);
        end
        frame(0, 1, 0, 1);
        frame(1, 0, 0, 1);
        frame(0, 0, 0, 1);
        DrawX = 100; DrawY = 10'(my); #1;
        checks++;
        if ({facing_left, is_sprite, sprite_address} !== {1'b1, 1'b1, 12'd31}) begin
            errors++;
            $display("FAIL pix_mirror: f=%0d is=%0d addr=%0d want 1 1 31", facing_left, is_sprite, sprite_address);
        end
        DrawX = 102; DrawY = 10'(my + 1); #1;
        checks++;
        if (sprite_address !== 12'd61) begin
            errors++; $display("FAIL pix_row: addr=%0d want 61", sprite_address);
        end
        DrawX = 132; DrawY = 10'(my); #1;
        checks++;
        if ({is_sprite, sprite_address} !== {1'b0, 12'd0}) begin
            errors++; $display("FAIL pix_right_edge: is=%0d addr=%0d want 0 0", is_sprite, sprite_address);
        end
        DrawX = 131; #1;
        checks++;
        if ({is_sprite, sprite_address} !== {1'b1, 12'd0}) begin
            errors++; $display("FAIL pix_last_col: is=%0d addr=%0d want 1 0", is_sprite, sprite_address);
        end
    endtask

    task automatic test_both_keys();
        for (int k = 0; k < 4; k++) begin
            frame(1, 1, 0, 1);
            checks++;
            if ({pos_x, facing_left, pose} !== {10'd100, 1'b1, 2'd0}) begin
                errors++;
                $display("FAIL both_keys k=%0d: x=%0d f=%0d p=%0d want 100 1 0", k, pos_x, facing_left, pose);
            end
        end
    endtask

    task automatic test_random();
        int dx, dy;
        bit l, r, j, s;
        for (int k = 0; k < 300; k++) begin
            l = ($urandom_range(0, 2) == 0); r = ($urandom_range(0, 2) == 0);
            j = ($urandom_range(0, 7) == 0); s = ($urandom_range(0, 5) == 0);
            frame(l, r, j, s);
            checks++;
            if ({pos_x, pos_y, facing_left, pose} !== {10'(mx), 10'(my), 1'(mfacing), 2'(mpose)}) begin
                errors++;
                $display("FAIL rand_motion k=%0d: x=%0d y=%0d f=%0d p=%0d want %0d %0d %0d %0d",
                         k, pos_x, pos_y, facing_left, pose, mx, my, mfacing, mpose);
            end
            for (int p = 0; p < 3; p++) begin
                dx = $urandom_range((mx > 8) ? mx - 8 : 0, mx + 40);
                dy = $urandom_range((my > 8) ? my - 8 : 0, (my + 40 > 1023) ? 1023 : my + 40);
                DrawX = 10'(dx); DrawY = 10'(dy); #1;
                checks++;
                if (sprite_address !== AW'(exp_addr(dx, dy)) || is_sprite !== (exp_addr(dx, dy) != 0 ||
                    (dx == mx + (mfacing ? SPR_W-1 : 0) && dy == my && mpose == 0))) begin
                    errors++;
                    $display("FAIL rand_pixel k=%0d (%0d,%0d): is=%0d addr=%0d want addr %0d",
                             k, dx, dy, is_sprite, sprite_address, exp_addr(dx, dy));
                end
            end
        end
    endtask

    task automatic test_reset_midjump();
        frame(0, 0, 0, 0);
        for (int k = 0; k < 40 && !(mmode == ON_GROUND && my == FLOOR_Y); k++) frame(0, 0, 0, 0);
        frame(0, 0, 1, 0);
        frame(0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1; frame_clk = 1; left_key = 1; right_key = 1;
        @(negedge Clk);
        model_reset();
        checks++;
        if ({pos_x, pos_y, facing_left, pose} !== {10'd40, 10'd400, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_midjump: x=%0d y=%0d f=%0d p=%0d want 40 400 0 0", pos_x, pos_y, facing_left, pose);
        end
        Reset = 0; frame_clk = 0;
        repeat (2) @(negedge Clk);
        for (int k = 0; k < 3; k++) begin
            frame(1, 1, 0, 1);
            checks++;
            if ({pos_x, pos_y, pose} !== {10'd40, 10'd400, 2'd0}) begin
                errors++;
                $display("FAIL reset_both_keys k=%0d: x=%0d y=%0d p=%0d want 40 400 0", k, pos_x, pos_y, pose);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_walk_left();
        test_jump();
        test_solid();
        test_pixel();
        test_both_keys();
        test_random();
        test_reset_midjump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
